// File: rtl/connection_block_sc_if.sv
// Serial configuration chain bundle for connection_block_sc.
// cfg_parity exists only when CB_PARITY_EN is defined.
interface connection_block_sc_if #(
  parameter int CFG_W = 8
);
  logic [CFG_W-1:0] cfg_in;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CFG_W-1:0] cfg_out;
  logic             cfg_out_valid;
  logic             cfg_out_ready;
  logic             cset;
  logic             cfg_full;
  logic             cfg_err;
`ifdef CB_PARITY_EN
  logic             cfg_parity;
`endif

  modport slave (
`ifdef CB_PARITY_EN
    input  cfg_parity,
`endif
    input  cfg_in, cfg_valid, cfg_out_ready, cset,
    output cfg_ready, cfg_out, cfg_out_valid, cfg_full, cfg_err
  );

  modport master (
`ifdef CB_PARITY_EN
    output cfg_parity,
`endif
    output cfg_in, cfg_valid, cfg_out_ready, cset,
    input  cfg_ready, cfg_out, cfg_out_valid, cfg_full, cfg_err
  );
endinterface

// File: rtl/connection_block_sc.sv
// Unidirectional connection block with daisy-chained, double-buffered configuration.
// Optional commit parity check enabled by defining CB_PARITY_EN.
//   state     | meaning
//   S_EMPTY   | no fresh words since reset/commit
//   S_FILLING | 1..CONF_WORDS-1 fresh words loaded
//   S_FULL    | shadow holds a complete image; accepts eject the oldest word
module connection_block_sc #(
  parameter int WS         = 8,
  parameter int WD         = 8,
  parameter int WG         = 3,
  parameter int CLBIN      = 6,
  parameter int CLBOUT     = 1,
  parameter int CARRY      = 1,
  parameter int CLBOS      = 2,
  parameter int CLBOD      = 2,
  parameter int CLBOS_BIAS = 0,
  parameter int CLBOD_BIAS = 0,
  parameter int CFG_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WS-1:0]     single0_in,
  input  logic [WS-1:0]     single1_in,
  output logic [WS-1:0]     single0_out,
  output logic [WS-1:0]     single1_out,
  input  logic [WD-1:0]     double0_in,
  input  logic [WD-1:0]     double1_in,
  output logic [WD-1:0]     double0_out,
  output logic [WD-1:0]     double1_out,
  input  logic [WG-1:0]     global_lines,
  input  logic [CLBOUT-1:0] clb0_output,
  input  logic [CLBOUT-1:0] clb1_output,
  input  logic [CARRY-1:0]  clb0_cout,
  input  logic [CARRY-1:0]  clb1_cout,
  output logic [CLBIN-1:0]  clb0_input,
  output logic [CLBIN-1:0]  clb1_input,
  output logic [CARRY-1:0]  clb0_cin,
  output logic [CARRY-1:0]  clb1_cin,
  connection_block_sc_if.slave cfg
);

  localparam int N_SRC      = 2*(WS+WD) + WG + CLBOUT;
  localparam int SEL_IN     = $clog2(N_SRC);
  localparam int SEL_OUT    = $clog2(2*CLBOUT + 1);
  localparam int SRC_PAD    = 2**SEL_IN;
  localparam int OUT_PAD    = 2**SEL_OUT;
  localparam int CONF_WIDTH = 2*CLBIN*SEL_IN + 2*SEL_OUT*(CLBOS+CLBOD);
  localparam int CONF_WORDS = (CONF_WIDTH + CFG_W - 1) / CFG_W;
  localparam int SH_W       = CONF_WORDS * CFG_W;
  localparam int CNT_W      = $clog2(CONF_WORDS + 1);
  localparam int OB         = 2*CLBIN*SEL_IN;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CONF_WORDS - 1);

  typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_FULL} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  err_q, err_d;
  logic [SH_W-1:0]       shadow_q;
  logic [CONF_WIDTH-1:0] active_q;
  logic                  accept, commit, parity_ok;

  assign cfg.cfg_full      = (state_q == S_FULL);
  assign cfg.cfg_ready     = !cfg.cfg_full | cfg.cfg_out_ready;
  assign cfg.cfg_out       = shadow_q[SH_W-1 -: CFG_W];
  assign cfg.cfg_out_valid = cfg.cfg_full & cfg.cfg_valid;
  assign cfg.cfg_err       = err_q;
  assign accept            = cfg.cfg_valid & cfg.cfg_ready;

`ifdef CB_PARITY_EN
  assign parity_ok = ((^shadow_q[CONF_WIDTH-1:0]) == cfg.cfg_parity);
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    commit  = 1'b0;
    if (cfg.cset) begin
      if (state_q == S_FULL && parity_ok) commit = 1'b1;
      else                                err_d  = 1'b1;
    end
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          count_d = CNT_W'(1);
          state_d = S_FILLING;
        end
      end
      S_FILLING: begin
        if (accept) begin
          count_d = count_q + 1'b1;
          if (count_q == LAST) state_d = S_FULL;
        end
      end
      S_FULL: begin
        // A word accepted alongside the commit starts the next load.
        if (commit) begin
          count_d = accept ? CNT_W'(1) : '0;
          state_d = accept ? S_FILLING : S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (accept) shadow_q <= {shadow_q[SH_W-CFG_W-1:0], cfg.cfg_in};
      if (commit) active_q <= shadow_q[CONF_WIDTH-1:0];
    end
  end

  logic [SRC_PAD-1:0] src0, src1;
  assign src0 = SRC_PAD'({clb1_output, global_lines, double1_in, double0_in, single1_in, single0_in});
  assign src1 = SRC_PAD'({clb0_output, global_lines, double1_in, double0_in, single1_in, single0_in});

  always_comb begin
    clb0_input = '0;
    clb1_input = '0;
    for (int i = 0; i < CLBIN; i++) begin
      clb0_input[i] = src0[active_q[i*SEL_IN +: SEL_IN]];
      clb1_input[i] = src1[active_q[(CLBIN+i)*SEL_IN +: SEL_IN]];
    end
  end

  function automatic logic omux(input logic [SEL_OUT-1:0] sel, input logic [2*CLBOUT:0] opts);
    logic [OUT_PAD-1:0] padded;
    padded = OUT_PAD'(opts);
    return padded[sel];
  endfunction

  always_comb begin
    single1_out = single0_in;
    single0_out = single1_in;
    double1_out = double0_in;
    double0_out = double1_in;
    for (int k = 0; k < CLBOS; k++) begin
      single1_out[(k + CLBOS_BIAS*CLBOS) % WS] =
        omux(active_q[OB + k*SEL_OUT +: SEL_OUT],
             {clb1_output, clb0_output, single0_in[(k + CLBOS_BIAS*CLBOS) % WS]});
      single0_out[(k + CLBOS_BIAS*CLBOS) % WS] =
        omux(active_q[OB + (CLBOS+k)*SEL_OUT +: SEL_OUT],
             {clb0_output, clb1_output, single1_in[(k + CLBOS_BIAS*CLBOS) % WS]});
    end
    for (int k = 0; k < CLBOD; k++) begin
      double1_out[(k + CLBOD_BIAS*CLBOD) % (WD/2)] =
        omux(active_q[OB + (2*CLBOS+k)*SEL_OUT +: SEL_OUT],
             {clb1_output, clb0_output, double0_in[(k + CLBOD_BIAS*CLBOD) % (WD/2)]});
      double0_out[(k + CLBOD_BIAS*CLBOD) % (WD/2)] =
        omux(active_q[OB + (2*CLBOS+CLBOD+k)*SEL_OUT +: SEL_OUT],
             {clb0_output, clb1_output, double1_in[(k + CLBOD_BIAS*CLBOD) % (WD/2)]});
    end
  end

  assign clb1_cin = clb0_cout;
  assign clb0_cin = clb1_cout;

endmodule

// File: doc/connection_block_sc.md
# connection_block_sc

Next-generation unidirectional connection block with a daisy-chained serial configuration port and double-buffered (shadow/active) configuration. It connects two CLBs to the single, double and global routing tracks of one channel segment, and to each other through direct links and the carry chain. Configuration is streamed in CFG_W-bit words through a valid/ready chain that spans every block in a tile row. A `cset` pulse commits the shadow image to the active routing in one edge, so routing never changes mid-load.

## Interface
- WS, 8, single tracks per direction
- WD, 8, double tracks per direction (even)
- WG, 3, global lines
- CLBIN, 6, inputs per CLB
- CLBOUT, 1, outputs per CLB
- CARRY, 1, carry bits
- CLBOS, 2, single tracks per direction drivable by CLB outputs
- CLBOD, 2, double tracks per direction drivable by CLB outputs
- CLBOS_BIAS, 0, single-track rotation index
- CLBOD_BIAS, 0, double-track rotation index
- CFG_W, 8, serial config word width
- Derived: SEL_IN = clog2(2(WS+WD)+WG+CLBOUT); SEL_OUT = clog2(2·CLBOUT+1); CONF_WIDTH = 2·CLBIN·SEL_IN + 2·SEL_OUT·(CLBOS+CLBOD); CONF_WORDS = ceil(CONF_WIDTH/CFG_W). Defaults give 88 bits, 11 words.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- single0_in, single1_in  in  WS  incoming single tracks
- single0_out, single1_out  out  WS  outgoing single tracks
- double0_in, double1_in  in  WD  incoming double tracks
- double0_out, double1_out  out  WD  outgoing double tracks
- global  in  WG  global lines
- clb0_output, clb1_output  in  CLBOUT  CLB outputs
- clb0_cout, clb1_cout  in  CARRY  carry out
- clb0_input, clb1_input  out  CLBIN  CLB inputs
- clb0_cin, clb1_cin  out  CARRY  carry in (cross-connected)
- cfg_in  in  CFG_W  config word
- cfg_valid  in  1  cfg_in valid
- cfg_ready  out  1  word accepted when valid & ready
- cfg_out  out  CFG_W  word shifted out to the next block
- cfg_out_valid  out  1  cfg_out valid
- cfg_out_ready  in  1  downstream ready
- cset  in  1  commit pulse
- cfg_full  out  1  shadow holds CONF_WORDS fresh words
- cfg_err  out  1  sticky: rejected commit

## Operation
- Shadow register is CONF_WORDS·CFG_W bits wide. Each accepted word shifts the shadow left by CFG_W; cfg_in enters the LSBs. The active register takes the low CONF_WIDTH bits.
- Load FSM:
  - EMPTY (count=0): an accept goes to FILLING.
  - FILLING: count increments on each accept; reaching CONF_WORDS goes to FULL.
  - FULL: count saturates.
- Chain handshake, all combinational:
  - cfg_ready = !cfg_full | cfg_out_ready.
  - cfg_out = top CFG_W bits of the shadow.
  - cfg_out_valid = cfg_full & cfg_valid.
  - In FULL, every accept ejects the oldest word downstream.
- Commit:
  - cset in FULL: active ← shadow at the edge; FSM goes to EMPTY.
  - cset outside FULL: ignored; sets cfg_err. cfg_err clears only on reset.
  - cset together with an accept: commit uses the pre-edge shadow; the accepted word counts as word 1 of the next load, so the FSM goes to FILLING.
- Input muxes:
  - clb0_input[i] selects from {clb1_output, global, double1, double0, single1, single0}, with index 0 = single0[0].
  - clb1_input is symmetric, with clb0_output in the MSBs.
  - Select codes past the valid range drive 0.
- Output muxes: for k < CLBOS, track t = (k + CLBOS_BIAS·CLBOS) mod WS:
  - single1_out[t] selects from {clb1_output, clb0_output, single0_in[t]}; code 0 = pass-through.
  - single0_out[t] is the mirror.
  - Doubles work the same way with CLBOD and modulus WD/2.
  - All other tracks pass straight through.
- Carry: clb1_cin = clb0_cout; clb0_cin = clb1_cout.

## Timing
- Reset (rst=0 at an edge):
  - shadow, active, count and cfg_err all go to 0; FSM goes to EMPTY.
  - With active = 0, every output mux passes through and every CLB input follows single0_in[0].
- Routing paths are combinational from the active register. New routing is visible the cycle after the cset edge.
- cfg_ready, cfg_out and cfg_out_valid are combinational from state and inputs. There is no bubble; one word per cycle is sustained.
- Reset during a load discards the partial load and leaves routing in the reset state.

## Configuration
- CB_PARITY_EN, when defined:
  - Adds input `cfg_parity` (1 bit), sampled with cset.
  - Commit requires XOR(shadow[CONF_WIDTH-1:0]) == cfg_parity.
  - On mismatch: no commit, cfg_err is set, FSM stays FULL.
- When undefined: no parity port, and commit depends only on FULL.

## Test plan
- Reset, then drive single0_in=8'hA5 with no load → single1_out=8'hA5 and clb0_input=6'h3F.
- Stream 11 words, then cset → cfg_full rises after word 11; after cset, a code selecting global[1] on clb0_input[0] makes it follow global[1].
- Stream 13 words with cfg_out_ready=0 after word 11 → cfg_ready drops at word 12 and no shift occurs until ready returns; words 1 and 2 then appear on cfg_out in order.
- cset after 5 words → routing unchanged and cfg_err=1; load 6 more words then cset → commit succeeds and cfg_err stays 1.
- cset in the same cycle as word 1 of the next load → old image is committed and count=1.
- With CB_PARITY_EN, flip cfg_parity → no commit, cfg_err=1, cfg_full stays 1.
